// File: rtl/dac16_output_data_transmitter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dac16_output_data_transmitter_if : AXI-Stream word bus feeding the DAC player
// Rev 1.0
// ---------------------------------------------------------------------------
interface dac16_output_data_transmitter_if;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tready;

  modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/dac16_output_data_transmitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dac16_output_data_transmitter : buffers 2x16-bit AXIS words and plays them out
// as a 16-bit DAC sample stream (FIFO + IDLE/FILL/PLAY sequencer).  Rev 1.0
// ---------------------------------------------------------------------------
module dac16_output_data_transmitter #(
  parameter int FIFO_DEPTH = 512,
  parameter int PRELOAD    = 16,
  parameter int SAMPLE_DIV = 1
) (
  input  logic                          s00_axis_aclk,
  input  logic                          s00_axis_areset,
  dac16_output_data_transmitter_if.slave s00_axis,
  input  logic [31:0]                   dsize,
  input  logic                          test,
  input  logic                          start,
  output logic [15:0]                   dac_data,
  output logic                          dac_valid,
  output logic                          dac_last,
  output logic                          sr_pc,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(SAMPLE_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(SAMPLE_DIV - 1);
  localparam logic [31:0]   PRELOAD_W = 32'(PRELOAD);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, PLAY = 2'd2} state_t;

  logic [32:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop;
  logic [32:0]   rd_word;
  logic          unused_tkeep;

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          test_q, test_d;
  logic          underrun_q, underrun_d;
  logic [15:0]   ramp_q, ramp_d;
  logic          half_q, half_d;
  logic [DW-1:0] div_q, div_d;
  logic [15:0]   dac_data_q, dac_data_d;
  logic          dac_valid_q, dac_valid_d;
  logic          dac_last_q, dac_last_d;
  logic          sr_pc_q, sr_pc_d;
  logic [31:0]   fill_thr;

  assign unused_tkeep    = ^s00_axis.tkeep;
  assign full            = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty           = (count_q == '0);
  assign s00_axis.tready = !full && !s00_axis_areset;
  assign push            = s00_axis.tvalid && s00_axis.tready;
  assign rd_word         = mem_q[rd_ptr_q];

  always_ff @(posedge s00_axis_aclk) begin
    if (push) mem_q[wr_ptr_q] <= {s00_axis.tlast, s00_axis.tdata};
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!push && pop) count_q <= count_q - (AW+1)'(1);
    end
  end

  // In FILL the word counter still holds the latched dsize.
  assign fill_thr = (cnt_q < PRELOAD_W) ? cnt_q : PRELOAD_W;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    test_d      = test_q;
    underrun_d  = underrun_q;
    ramp_d      = ramp_q;
    half_d      = half_q;
    div_d       = div_q;
    dac_data_d  = dac_data_q;
    dac_valid_d = 1'b0;
    dac_last_d  = 1'b0;
    sr_pc_d     = (state_q == IDLE);
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          underrun_d = 1'b0;
          if (dsize != 32'd0) begin
            cnt_d   = dsize;
            test_d  = test;
            ramp_d  = 16'd0;
            half_d  = 1'b0;
            div_d   = '0;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (test_q || (32'(count_q) >= fill_thr)) begin
          div_d   = '0;
          half_d  = 1'b0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        // Starved tick: divider and half are frozen so the tick retries each cycle.
        if (div_q == '0 && !test_q && !half_q && empty) begin
          underrun_d = 1'b1;
        end else begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
          if (div_q == '0) begin
            dac_valid_d = 1'b1;
            dac_data_d  = test_q ? ramp_q : (half_q ? rd_word[31:16] : rd_word[15:0]);
            if (test_q) ramp_d = ramp_q + 16'd1;
            half_d = !half_q;
            if (half_q) begin
              pop   = !test_q;
              cnt_d = cnt_q - 32'd1;
              if (cnt_q == 32'd1 || (!test_q && rd_word[32])) begin
                dac_last_d = 1'b1;
                state_d    = IDLE;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      test_q      <= 1'b0;
      underrun_q  <= 1'b0;
      ramp_q      <= '0;
      half_q      <= 1'b0;
      div_q       <= '0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      dac_last_q  <= 1'b0;
      sr_pc_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      test_q      <= test_d;
      underrun_q  <= underrun_d;
      ramp_q      <= ramp_d;
      half_q      <= half_d;
      div_q       <= div_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      dac_last_q  <= dac_last_d;
      sr_pc_q     <= sr_pc_d;
    end
  end

  assign dac_data   = dac_data_q;
  assign dac_valid  = dac_valid_q;
  assign dac_last   = dac_last_q;
  assign sr_pc      = sr_pc_q;
  assign underrun   = underrun_q;
  assign fifo_count = count_q;
endmodule
`default_nettype wire

// File: tb/tb_dac16_output_data_transmitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dac16_output_data_transmitter : directed bench, two instances (DIV=1 / DIV=4)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dac16_output_data_transmitter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dac16_output_data_transmitter_if ifa();
  dac16_output_data_transmitter_if ifb();

  logic [31:0] dsize_a = '0, dsize_b = '0;
  logic        test_a = 1'b0, test_b = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic [15:0] dd_a, dd_b;
  logic        dv_a, dv_b, dl_a, dl_b, sr_a, sr_b, ur_a, ur_b;
  logic [4:0]  fc_a, fc_b;

  dac16_output_data_transmitter #(.FIFO_DEPTH(16), .PRELOAD(2), .SAMPLE_DIV(1)) u_a (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(ifa),
    .dsize(dsize_a), .test(test_a), .start(start_a),
    .dac_data(dd_a), .dac_valid(dv_a), .dac_last(dl_a), .sr_pc(sr_a),
    .underrun(ur_a), .fifo_count(fc_a));

  dac16_output_data_transmitter #(.FIFO_DEPTH(16), .PRELOAD(16), .SAMPLE_DIV(4)) u_b (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .s00_axis(ifb),
    .dsize(dsize_b), .test(test_b), .start(start_b),
    .dac_data(dd_b), .dac_valid(dv_b), .dac_last(dl_b), .sr_pc(sr_b),
    .underrun(ur_b), .fifo_count(fc_b));

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] qa_d[$], qb_d[$];
  bit          qa_l[$], qb_l[$];
  int          qa_c[$], qb_c[$];
  bit          prev_last_a = 1'b0, prev_last_b = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_last_a) chk("a_sr_pc_after_last", sr_a, 1);
      if (prev_last_b) chk("b_sr_pc_after_last", sr_b, 1);
      if (dv_a) begin qa_d.push_back(dd_a); qa_l.push_back(dl_a); qa_c.push_back(cyc); end
      if (dv_b) begin qb_d.push_back(dd_b); qb_l.push_back(dl_b); qb_c.push_back(cyc); end
      prev_last_a = dv_a && dl_a;
      prev_last_b = dv_b && dl_b;
    end else begin
      prev_last_a = 1'b0;
      prev_last_b = 1'b0;
    end
  end

  task automatic clr_a();
    qa_d.delete(); qa_l.delete(); qa_c.delete();
  endtask

  task automatic push_a(input logic [31:0] d, input logic l);
    @(negedge clk);
    ifa.tvalid = 1'b1; ifa.tdata = d; ifa.tlast = l;
    @(posedge clk);
  endtask

  task automatic idle_a();
    @(negedge clk);
    ifa.tvalid = 1'b0; ifa.tlast = 1'b0;
  endtask

  task automatic start_pulse_a(input logic [31:0] ds);
    @(negedge clk);
    start_a = 1'b1; dsize_a = ds; test_a = 1'b0;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_a(input int n, input int budget, input string tag);
    int k = 0;
    while (qa_d.size() < n && k < budget) begin @(negedge clk); k++; end
    chk(tag, qa_d.size(), n);
  endtask

  function automatic logic [31:0] seq_word(input int i);
    return {16'(2*i + 2), 16'(2*i + 1)};
  endfunction

  initial begin
    ifa.tvalid = 1'b0; ifa.tdata = '0; ifa.tkeep = 4'hF; ifa.tlast = 1'b0;
    ifb.tvalid = 1'b0; ifb.tdata = '0; ifb.tkeep = 4'hF; ifb.tlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tready_low", ifa.tready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tready", ifa.tready, 1);
    chk("rst_sr_pc", sr_a, 1);
    chk("rst_valid", dv_a, 0);
    chk("rst_data", dd_a, 0);
    chk("rst_last", dl_a, 0);
    chk("rst_underrun", ur_a, 0);
    chk("rst_count", fc_a, 0);

    // Basic playback of 4 preloaded words
    clr_a();
    for (int i = 0; i < 4; i++) push_a(seq_word(i), 1'b0);
    idle_a();
    chk("t1_count_pre", fc_a, 4);
    start_pulse_a(4);
    wait_a(8, 60, "t1_nsamp");
    for (int i = 0; i < qa_d.size() && i < 8; i++) begin
      chk("t1_data", qa_d[i], i + 1);
      chk("t1_last", qa_l[i], (i == 7) ? 1 : 0);
      if (i > 0) chk("t1_spacing", qa_c[i] - qa_c[i-1], 1);
    end
    repeat (3) @(negedge clk);
    chk("t1_underrun", ur_a, 0);
    chk("t1_sr_pc", sr_a, 1);
    chk("t1_count_post", fc_a, 0);

    // Ramp mode on the divided instance; its FIFO word must stay put
    @(negedge clk);
    ifb.tvalid = 1'b1; ifb.tdata = 32'h1234_5678;
    @(negedge clk);
    ifb.tvalid = 1'b0;
    start_b = 1'b1; dsize_b = 3; test_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0; test_b = 1'b0; dsize_b = 100;
    begin
      int k = 0;
      while (qb_d.size() < 6 && k < 80) begin @(negedge clk); k++; end
    end
    chk("t2_nsamp", qb_d.size(), 6);
    for (int i = 0; i < qb_d.size() && i < 6; i++) begin
      chk("t2_ramp", qb_d[i], i);
      chk("t2_last", qb_l[i], (i == 5) ? 1 : 0);
      if (i > 0) chk("t2_spacing", qb_c[i] - qb_c[i-1], 4);
    end
    repeat (6) @(negedge clk);
    chk("t2_extra", qb_d.size(), 6);
    chk("t2_fifo_untouched", fc_b, 1);

    // Starvation mid-packet
    clr_a();
    for (int i = 0; i < 2; i++) push_a(seq_word(i), 1'b0);
    idle_a();
    start_pulse_a(8);
    repeat (20) @(negedge clk);
    chk("t3_underrun", ur_a, 1);
    chk("t3_hold", dd_a, 4);
    chk("t3_nsamp_stall", qa_d.size(), 4);
    for (int i = 2; i < 8; i++) push_a(seq_word(i), 1'b0);
    idle_a();
    wait_a(16, 80, "t3_nsamp");
    for (int i = 0; i < qa_d.size() && i < 16; i++) begin
      chk("t3_data", qa_d[i], i + 1);
      chk("t3_last", qa_l[i], (i == 15) ? 1 : 0);
    end
    repeat (3) @(negedge clk);
    chk("t3_underrun_sticky", ur_a, 1);

    // Early tlast, and start clears underrun
    clr_a();
    for (int i = 0; i < 3; i++) push_a(seq_word(i), (i == 2));
    idle_a();
    start_pulse_a(10);
    chk("t4_underrun_cleared", ur_a, 0);
    wait_a(6, 40, "t4_nsamp");
    repeat (10) @(negedge clk);
    chk("t4_no_extra", qa_d.size(), 6);
    for (int i = 0; i < qa_d.size() && i < 6; i++) begin
      chk("t4_data", qa_d[i], i + 1);
      chk("t4_last", qa_l[i], (i == 5) ? 1 : 0);
    end
    chk("t4_sr_pc", sr_a, 1);
    chk("t4_count", fc_a, 0);

    // Fill to full in IDLE; refused extra word; pop reopens tready
    clr_a();
    for (int i = 0; i < 16; i++) push_a({16'h5000 + 16'(i), 16'hA000 + 16'(i)}, 1'b0);
    @(negedge clk);
    ifa.tdata = 32'hDEAD_BEEF;
    chk("t5_tready_full", ifa.tready, 0);
    chk("t5_count_full", fc_a, 16);
    @(negedge clk);
    ifa.tvalid = 1'b0;
    chk("t5_count_hold", fc_a, 16);
    start_pulse_a(1);
    wait_a(2, 20, "t5_nsamp1");
    if (qa_d.size() >= 2) begin
      chk("t5_w0_lo", qa_d[0], 16'hA000);
      chk("t5_w0_hi", qa_d[1], 16'h5000);
      chk("t5_w0_last", qa_l[1], 1);
    end
    repeat (2) @(negedge clk);
    chk("t5_tready_reopen", ifa.tready, 1);
    chk("t5_count_15", fc_a, 15);
    clr_a();
    start_pulse_a(15);
    wait_a(30, 100, "t5_nsamp_drain");
    for (int i = 0; i < qa_d.size() && i < 30; i++) begin
      chk("t5_drain", qa_d[i], (i % 2) ? 16'h5000 + 16'(1 + i/2) : 16'hA000 + 16'(1 + i/2));
    end
    repeat (3) @(negedge clk);
    chk("t5_count_empty", fc_a, 0);

    // Reset in the middle of playback
    clr_a();
    for (int i = 0; i < 4; i++) push_a(seq_word(i), 1'b0);
    idle_a();
    start_pulse_a(4);
    wait_a(3, 30, "t6_nsamp");
    rst = 1'b1;
    @(negedge clk);
    chk("t6_valid", dv_a, 0);
    chk("t6_last", dl_a, 0);
    chk("t6_count", fc_a, 0);
    chk("t6_tready_rst", ifa.tready, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_sr_pc", sr_a, 1);
    chk("t6_idle_valid", dv_a, 0);
    begin
      int nl = 0;
      foreach (qa_l[i]) if (qa_l[i]) nl++;
      chk("t6_no_last", nl, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dac16_output_data_transmitter.md
# dac16_output_data_transmitter

AXI-Stream slave that accepts 32-bit words (two 16-bit samples each) from the DMA/PS side, buffers them in an internal synchronous FIFO, and plays them out as a parallel 16-bit sample stream toward the DAC front end. It is the playback counterpart of the ADC capture path and uses the same packet-size, start, test-ramp and packet-complete semantics. Single clock domain; the DAC interface is clocked by the same stream clock.

## Interface

- FIFO_DEPTH, 512 — FIFO depth in 32-bit words; power of two, 16..4096.
- PRELOAD, 16 — minimum words buffered before playback starts; 1..FIFO_DEPTH.
- SAMPLE_DIV, 1 — clocks per output sample; 1..256.

- s00_axis_aclk  in  1  stream and DAC clock.
- s00_axis_areset  in  1  synchronous, active-high reset.
- s00_axis_tvalid  in  1  input word valid.
- s00_axis_tdata  in  32  [15:0] earlier sample, [31:16] later sample.
- s00_axis_tkeep  in  4  ignored.
- s00_axis_tlast  in  1  last word of packet; stored with the word.
- s00_axis_tready  out  1  high when FIFO not full.
- dsize  in  32  words per packet; latched at start.
- test  in  1  ramp mode; latched at start.
- start  in  1  playback start; sampled only in IDLE.
- dac_data  out  16  output sample.
- dac_valid  out  1  one-cycle strobe per new sample.
- dac_last  out  1  with dac_valid on the final sample of the packet.
- sr_pc  out  1  high in IDLE (packet complete / ready).
- underrun  out  1  sticky; set on FIFO starvation during PLAY; cleared by start or reset.
- fifo_count  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation

- FIFO: 33 bits wide (tdata + tlast). Push on tvalid & tready; pop on word retire in PLAY. Push and pop in same cycle: count unchanged. Full: tready=0, no push. Pop never occurs when empty.
- FIFO fills in every state, including IDLE (pre-buffering).
- States: IDLE, FILL, PLAY.
- IDLE: sr_pc=1. On start with dsize!=0: latch dsize to word counter, latch test, clear underrun, clear ramp to 0, go FILL. start with dsize==0: clear underrun only, stay IDLE.
- FILL: go PLAY when test=1, or fifo_count >= min(PRELOAD, dsize).
- PLAY: sample tick every SAMPLE_DIV clocks (divider reset to 0 on PLAY entry, tick on first PLAY cycle). Each word yields two ticks: half 0 emits [15:0], half 1 emits [31:16]; after half 1 the word retires (pop, counter-1).
- Test mode: sample = 16-bit ramp, +1 per tick, wraps 0xFFFF→0x0000; FIFO not popped; counter still decremented per two ticks.
- Starvation: tick in half 0 with FIFO empty (non-test) → no dac_valid, dac_data holds, underrun=1, half/divider hold until data arrives; playback resumes on the next tick with data.
- End: the word retiring when counter reaches 1, or whose stored tlast=1, is final; its half-1 sample carries dac_last=1; next state IDLE. tlast mid-packet ends early; remaining counter discarded. tlast in the first half of the final word still emits both samples.
- start, dsize, test changes outside IDLE ignored.
- Reset: state IDLE, FIFO empty, counter 0, divider 0, ramp 0; outputs dac_data=0, dac_valid=0, dac_last=0, underrun=0, tready=0 during reset and 1 the cycle after, sr_pc=1 the cycle after reset deasserts. Reset mid-PLAY aborts without dac_last.

## Timing

- All outputs registered except s00_axis_tready (combinational from FIFO full, gated low while reset asserted).
- start in IDLE at cycle t → FILL t+1 → PLAY t+2 (if threshold met) → first dac_valid t+3.
- SAMPLE_DIV=1: dac_valid continuous while data available; 2 clocks per word.
- Pushed word visible to PLAY one cycle after the push (fifo_count updates next cycle).
- dac_last coincident with final dac_valid; sr_pc rises the cycle after.

## Test plan

- Preload 4 words 0x00020001,0x00040003,0x00060005,0x00080007, PRELOAD=4, dsize=4, start → dac_data 1..8 on 8 consecutive dac_valid, dac_last on 8, sr_pc high 1 cycle later, underrun=0.
- test=1, dsize=3, SAMPLE_DIV=4 → six dac_valid strobes 4 clocks apart with 0,1,2,3,4,5; FIFO untouched; dac_last on 5.
- dsize=8, 2 words preloaded with PRELOAD=2, remaining words fed after 20-cycle gap → underrun=1, dac_data holds sample 4, playback resumes with sample 5, 16 samples total.
- dsize=10, tlast on word 3 → 6 samples, dac_last on sample 6, return to IDLE; next start clears underrun.
- Fill FIFO to FIFO_DEPTH in IDLE → tready=0, fifo_count=FIFO_DEPTH, no data lost; one pop → tready=1.
- Assert reset mid-PLAY → next cycle dac_valid=0, fifo_count=0, state IDLE, no dac_last.
